muldiv_unit: RTL and testbench

- Parametrised iterative multiply/divide unit implementing the RV32M/RV64M operation set (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU).
- Successor execution resource for the datapath: sits beside the ALU and takes rdata1/rdata2 as operands.
- The controller stalls the PC while busy is high, and selects result on the writeback mux when done pulses.
- Operand width is the XLEN parameter.

---
 rtl/muldiv_pkg.sv | 20 ++
 rtl/muldiv_sign_fix.sv | 20 ++
 rtl/muldiv_unit.sv | 114 +++++++++++
 tb/tb_muldiv_unit.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared encodings and constant helpers for the multiply/divide unit
package muldiv_pkg;
  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_e;
  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIN = 2'd2} muldiv_state_e;
  function automatic logic [63:0] most_neg(int xlen);
    return 64'd1 << (xlen - 1);
  endfunction
  function automatic logic [63:0] all_ones(int xlen);
    return {64{1'b1}} >> (64 - xlen);
  endfunction
endpackage

// File: rtl/muldiv_sign_fix.sv
// muldiv_sign_fix: turns a magnitude product or {remainder, quotient} into the signed XLEN result
// Ports: op (func3), mag (2*XLEN magnitude), neg_a/neg_b (operand sign flags), res (corrected result).
module muldiv_sign_fix import muldiv_pkg::*; #(
  parameter int XLEN = 32
) (
  input  logic [2:0]        op,
  input  logic [2*XLEN-1:0] mag,
  input  logic              neg_a,
  input  logic              neg_b,
  output logic [XLEN-1:0]   res
);
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0] quo, rem;
  always_comb begin
    prod = (neg_a ^ neg_b) ? -mag : mag;
    quo  = (neg_a ^ neg_b) ? -mag[XLEN-1:0] : mag[XLEN-1:0];
    rem  = neg_a ? -mag[2*XLEN-1:XLEN] : mag[2*XLEN-1:XLEN];
    res  = op[2] ? (op[1] ? rem : quo) : (op == OP_MUL ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]);
  end
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M/RV64M multiply/divide unit (shift-add multiply, restoring divide)
// Ports: clk, reset (async, active-high), start/func3/op_a/op_b request, busy (CALC only),
// done (one-cycle pulse), result (held until the next accepted request).
// Optional MULDIV_FAST_MUL_EN: multiplies use a single-cycle combinational product.
module muldiv_unit import muldiv_pkg::*; #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      func3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);
  localparam int CNT_W = $clog2(XLEN);
  localparam logic [XLEN-1:0] MOST_NEG = XLEN'(most_neg(XLEN));
  localparam logic [XLEN-1:0] ALL_ONES = XLEN'(all_ones(XLEN));
  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_CALC = CALC;
  localparam logic [1:0] S_FIN  = FIN;
  logic [1:0] state_q, state_d;
  logic [2:0] op_q, op_d;
  logic [XLEN-1:0] m_q, m_d, result_q, result_d, mag_a, mag_b, fixed;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic neg_a_q, neg_a_d, neg_b_q, neg_b_d, done_q, done_d, neg_a, neg_b, div_short;
  logic [XLEN:0] msum, dsub;
  muldiv_sign_fix #(.XLEN(XLEN)) u_fix (
    .op(op_q), .mag(acc_q), .neg_a(neg_a_q), .neg_b(neg_b_q), .res(fixed)
  );
  // m_q holds the operand reused every iteration: multiplicand for multiplies, divisor for divides.
  // acc_q is {partial, multiplier} for multiplies and {remainder, dividend/quotient} for divides.
  always_comb begin
    neg_a = (func3[2] ? !func3[0] : func3 != OP_MULHU) && op_a[XLEN-1];
    neg_b = (func3[2] ? !func3[0] : !func3[1]) && op_b[XLEN-1];
    mag_a = neg_a ? -op_a : op_a;
    mag_b = neg_b ? -op_b : op_b;
    div_short = op_b == '0 || (!func3[0] && op_a == MOST_NEG && op_b == ALL_ONES);
    msum = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, {XLEN{acc_q[0]}} & m_q};
    dsub = acc_q[2*XLEN-1:XLEN-1] - {1'b0, m_q};
    state_d = state_q;
    op_d = op_q;
    m_d = m_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    neg_a_d = neg_a_q;
    neg_b_d = neg_b_q;
    result_d = result_q;
    done_d = 1'b0;
    if (state_q == S_IDLE) begin
      if (start) begin
        op_d = func3;
        neg_a_d = neg_a;
        neg_b_d = neg_b;
        cnt_d = '0;
        if (func3[2]) begin
          // Shortcut results are preloaded as {rem, quo} with clear signs so sign_fix passes them through.
          m_d = mag_b;
          acc_d = op_b == '0 ? {op_a, ALL_ONES} : div_short ? {{XLEN{1'b0}}, op_a} : {{XLEN{1'b0}}, mag_a};
          neg_a_d = neg_a && !div_short;
          neg_b_d = neg_b && !div_short;
          state_d = div_short ? S_FIN : S_CALC;
        end else begin
`ifdef MULDIV_FAST_MUL_EN
          acc_d = {{XLEN{1'b0}}, mag_a} * {{XLEN{1'b0}}, mag_b};
          state_d = S_FIN;
`else
          m_d = mag_a;
          acc_d = {{XLEN{1'b0}}, mag_b};
          state_d = S_CALC;
`endif
        end
      end
    end else if (state_q == S_CALC) begin
      acc_d = op_q[2] ? (dsub[XLEN] ? {acc_q[2*XLEN-2:0], 1'b0} : {dsub[XLEN-1:0], acc_q[XLEN-2:0], 1'b1})
                      : {msum, acc_q[XLEN-1:1]};
      cnt_d = cnt_q + 1'b1;
      state_d = cnt_q == CNT_W'(XLEN - 1) ? S_FIN : S_CALC;
    end else begin
      result_d = fixed;
      done_d = 1'b1;
      state_d = S_IDLE;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      op_q <= '0;
      m_q <= '0;
      acc_q <= '0;
      cnt_q <= '0;
      neg_a_q <= 1'b0;
      neg_b_q <= 1'b0;
      result_q <= '0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q <= op_d;
      m_q <= m_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      neg_a_q <= neg_a_d;
      neg_b_q <= neg_b_d;
      result_q <= result_d;
      done_q <= done_d;
    end
  end
  assign busy = state_q == S_CALC;
  assign done = done_q;
  assign result = result_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: randomized and directed checks of muldiv_unit against a behavioural model
module tb_muldiv_unit;
  logic clk = 1'b0, reset = 1'b0, start = 1'b0;
  logic [2:0] func3 = '0;
  logic [31:0] op_a = '0, op_b = '0;
  logic busy, done;
  logic [31:0] result;
  int errors = 0, checks = 0;
  bit m_active = 1'b0;
  int m_j = 0, m_l = 0;
  logic [31:0] m_res = '0, m_pend = '0;

  muldiv_unit #(.XLEN(32)) dut (
    .clk(clk), .reset(reset), .start(start), .func3(func3), .op_a(op_a), .op_b(op_b),
    .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_res(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint x, y, p;
    x = (f inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd6}) ? longint'($signed(a)) : longint'({32'b0, a});
    y = (f inside {3'd0, 3'd1, 3'd4, 3'd6}) ? longint'($signed(b)) : longint'({32'b0, b});
    if (!f[2]) begin
      p = x * y;
      return f == 3'd0 ? p[31:0] : p[63:32];
    end
    if (b == 32'h0) return f[1] ? a : 32'hFFFFFFFF;
    if (!f[0] && a == 32'h80000000 && b == 32'hFFFFFFFF) return f[1] ? 32'h0 : a;
    p = f[1] ? x % y : x / y;
    return p[31:0];
  endfunction

  function automatic int ref_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
`ifdef MULDIV_FAST_MUL_EN
    if (!f[2]) return 1;
`endif
    if (f[2] && (b == 32'h0 || (!f[0] && a == 32'h80000000 && b == 32'hFFFFFFFF))) return 1;
    return 33;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom % 6)
      0: return 32'h0;
      1: return 32'hFFFFFFFF;
      2: return 32'h80000000;
      3: return 32'($urandom % 16);
      default: return 32'($urandom);
    endcase
  endfunction

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  // Model: j counts edges since acceptance; done at j==L, busy while the iterations run.
  always @(posedge clk or posedge reset) begin : model
    bit idle;
    if (reset) begin
      m_active = 1'b0;
      m_res = '0;
    end else begin
      idle = !m_active || m_j == m_l;
      if (m_active && m_j == m_l) m_active = 1'b0;
      else if (m_active) begin
        m_j++;
        if (m_j == m_l) m_res = m_pend;
      end
      if (idle && start) begin
        m_active = 1'b1;
        m_j = 0;
        m_l = ref_lat(func3, op_a, op_b);
        m_pend = ref_res(func3, op_a, op_b);
      end
    end
  end

  always @(negedge clk) begin
    chk("busy", busy, m_active && m_j < m_l - 1);
    chk("done", done, m_active && m_j == m_l);
    chk("result", result, m_res);
  end

  task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input string nm);
    int n, l;
    l = ref_lat(f, a, b);
    @(negedge clk);
    start = 1'b1; func3 = f; op_a = a; op_b = b;
    @(negedge clk);
    n = 0;
    while (!done && n < 100) begin
      start = n < l ? 1'($urandom) : 1'b0;
      func3 = 3'($urandom); op_a = $urandom; op_b = $urandom;
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    chk({nm, "_latency"}, n, l);
    chk({nm, "_result"}, result, exp);
  endtask

  initial begin
    int dn;
    #1 reset = 1'b1;
    @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_result", result, 0);
    @(negedge clk);
    reset = 1'b0;
    chk("model_mul", ref_res(3'd0, 32'd7, 32'hFFFFFFFD), 32'hFFFFFFEB);
    chk("model_mulhu", ref_res(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF), 32'hFFFFFFFE);
    chk("model_mulhsu", ref_res(3'd2, 32'hFFFFFFFF, 32'd2), 32'hFFFFFFFF);
    chk("model_div", ref_res(3'd4, -32'sd7, 32'd2), 32'hFFFFFFFD);
    chk("model_rem", ref_res(3'd6, -32'sd7, 32'd2), 32'hFFFFFFFF);
    do_op(3'd0, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, "mul");
    do_op(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, "mulhu");
    do_op(3'd2, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, "mulhsu");
    do_op(3'd1, 32'h80000000, 32'h80000000, 32'h40000000, "mulh");
    do_op(3'd4, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, "div");
    do_op(3'd6, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, "rem");
    do_op(3'd5, 32'd100, 32'd7, 32'd14, "divu");
    do_op(3'd7, 32'd100, 32'd7, 32'd2, "remu");
    do_op(3'd4, 32'd5, 32'd0, 32'hFFFFFFFF, "div_zero");
    do_op(3'd6, 32'd5, 32'd0, 32'd5, "rem_zero");
    do_op(3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, "div_ovf");
    do_op(3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h0, "rem_ovf");
    do_op(3'd5, 32'd100, 32'd7, 32'd14, "divu_held");
    @(negedge clk);
    start = 1'b1; func3 = 3'd5; op_a = 32'd1000; op_b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("midop_reset_busy", busy, 0);
    chk("midop_reset_done", done, 0);
    chk("midop_reset_result", result, 0);
    @(negedge clk);
    reset = 1'b0;
    dn = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) dn++;
    end
    chk("no_done_after_reset", dn, 0);
    do_op(3'd0, 32'd3, 32'd4, 32'd12, "mul_after_reset");
    for (int i = 0; i < 150; i++) begin
      logic [2:0] f;
      logic [31:0] a, b;
      f = 3'($urandom % 8);
      a = pick();
      b = pick();
      do_op(f, a, b, ref_res(f, a, b), "rand");
    end
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
